// File: rtl/deci_pkg.sv
// Types and defaults shared by the LPDAQ decimation blocks and the downstream packer.
package deci_pkg;

    localparam int DEF_DW   = 10;
    localparam int DEF_NCH  = 4;
    localparam int DEF_DECI = 5;
    localparam int DEF_CW   = $clog2(DEF_NCH);

    typedef logic [DEF_CW-1:0]        chan_idx_t;
    typedef logic signed [DEF_DW-1:0] sample_t;

    // Increment modulo n, used for round-robin pointer stepping.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, with wrap.
module rr_arbiter
    import deci_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int            pos;
    logic [IW-1:0] sel;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no path leaves one unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = int'(ptr);
        sel     = '0;
        for (int i = 0; i < N; i++) begin
            sel = IW'(pos);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
            pos = wrap_inc(pos, N);
        end
    end

endmodule

// File: rtl/deci_rr_sched.sv
// Round-robin decimating scheduler: NCH channels with private modulo-DECI counters
// share one registered valid/ready output stage.
module deci_rr_sched
    import deci_pkg::*;
#(
    parameter int  DW   = DEF_DW,
    parameter int  NCH  = DEF_NCH,
    parameter int  DECI = DEF_DECI,
    localparam int CW   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*DW-1:0]    in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH-1:0]       ch_en,
    input  logic                 cnt_clr,
    output logic signed [DW-1:0] out_data,
    output logic [CW-1:0]        out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int              CNTW = (DECI > 1) ? $clog2(DECI) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(DECI - 1);

    logic [CNTW-1:0] cnt_q [NCH];
    logic [CNTW-1:0] cnt_d [NCH];
    logic [CW-1:0]   ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]   out_chan_q, out_chan_d;

    logic            stage_free;
    logic [NCH-1:0]  at_last;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  gnt;
    logic [CW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            emit;
    logic [DW-1:0]   gnt_sample;

    // A channel whose next sample would be emitted may only go when the output stage can take it.
    always_comb begin
        stage_free = ~out_valid_q | out_ready;
        for (int c = 0; c < NCH; c++) begin
            at_last[c] = (cnt_q[c] == LAST);
            req[c]     = rst_n & ~cnt_clr & in_valid[c] & ch_en[c] & (~at_last[c] | stage_free);
        end
    end

    rr_arbiter #(.N(NCH)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign in_ready   = gnt;
    assign emit       = gnt_any & at_last[gnt_idx];
    assign gnt_sample = in_data[gnt_idx*DW +: DW];

    always_comb begin
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;

        for (int c = 0; c < NCH; c++) begin
            if (cnt_clr || !ch_en[c]) begin
                cnt_d[c] = '0;
            end else if (gnt[c]) begin
                cnt_d[c] = at_last[c] ? '0 : cnt_q[c] + 1'b1;
            end
        end

        if (cnt_clr) begin
            ptr_d = '0;
        end else if (gnt_any) begin
            ptr_d = CW'(wrap_inc(int'(gnt_idx), NCH));
        end

        // Emission wins over a simultaneous handshake: the stage reloads and stays valid.
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_sample;
            out_chan_d  = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the counter array is phase state, not storage, so every entry is reset explicitly.
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
            end
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_deci_rr_sched.sv
// Self-checking bench for deci_rr_sched: vector table, directed corner sequences and a random run against a reference model.
module tb_deci_rr_sched;
    import deci_pkg::*;

    localparam int DW   = 10;
    localparam int NCH  = 4;
    localparam int DECI = 5;
    localparam int CW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH-1:0]    ch_en;
    logic              cnt_clr;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_chan;
    logic              out_valid;
    logic              out_ready;

    always #5 clk = ~clk;

    deci_rr_sched #(.DW(DW), .NCH(NCH), .DECI(DECI)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .cnt_clr   (cnt_clr),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: sample counts per channel, a rotating pointer and one output slot.
    int            m_cnt [NCH];
    int            m_ptr = 0;
    bit            m_ov  = 1'b0;
    logic [DW-1:0] m_od  = '0;
    int            m_oc  = 0;
    int            m_gnt = -1;
    logic [NCH-1:0] m_ready;

    task automatic model_predict();
        bit free;
        m_gnt   = -1;
        m_ready = '0;
        if (rst_n && !cnt_clr) begin
            free = !m_ov || out_ready;
            for (int i = 0; i < NCH; i++) begin
                int c = (m_ptr + i) % NCH;
                if (m_gnt < 0 && in_valid[c] && ch_en[c] && (m_cnt[c] != DECI - 1 || free))
                    m_gnt = c;
            end
            if (m_gnt >= 0) m_ready[m_gnt] = 1'b1;
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
            m_ptr = 0; m_ov = 1'b0; m_od = '0; m_oc = 0;
            return;
        end
        if (m_gnt >= 0 && m_cnt[m_gnt] == DECI - 1) begin
            m_ov = 1'b1;
            m_od = in_data[m_gnt*DW +: DW];
            m_oc = m_gnt;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (cnt_clr || !ch_en[c]) m_cnt[c] = 0;
            else if (c == m_gnt)      m_cnt[c] = (m_cnt[c] + 1) % DECI;
        end
        if (cnt_clr)         m_ptr = 0;
        else if (m_gnt >= 0) m_ptr = (m_gnt + 1) % NCH;
    endtask

    function automatic logic [NCH*DW-1:0] mk4(input int d0, input int d1, input int d2, input int d3);
        return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    task automatic apply(input logic [NCH-1:0] vin, input logic [NCH-1:0] en, input logic clr,
                         input logic ordy, input logic rstn, input logic [NCH*DW-1:0] data);
        @(negedge clk);
        in_valid  = vin;
        ch_en     = en;
        cnt_clr   = clr;
        out_ready = ordy;
        rst_n     = rstn;
        in_data   = data;
        #1;
        model_predict();
    endtask

    task automatic model_check();
        check("model in_ready",  32'(in_ready),  32'(m_ready));
        check("model out_valid", 32'(out_valid), 32'(m_ov));
        check("model out_data",  32'(out_data),  32'(m_od));
        check("model out_chan",  32'(out_chan),  32'(m_oc));
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
    endtask

    task automatic step(input logic [NCH-1:0] vin, input logic [NCH-1:0] en, input logic clr,
                        input logic ordy, input logic rstn, input logic [NCH*DW-1:0] data);
        apply(vin, en, clr, ordy, rstn, data);
        model_check();
        adv();
    endtask

    typedef struct {
        logic [NCH-1:0] vin;
        logic           rstn;
        logic [DW-1:0]  d0;
        logic [NCH-1:0] exp_ready;
        logic           exp_ov;
        logic [DW-1:0]  exp_od;
        logic [CW-1:0]  exp_oc;
    } vec_t;

    function automatic vec_t mkv(input logic [NCH-1:0] vin, input logic rstn, input int d0,
                                 input logic [NCH-1:0] rdy, input logic ov, input int od);
        vec_t v;
        v.vin = vin; v.rstn = rstn; v.d0 = DW'(d0);
        v.exp_ready = rdy; v.exp_ov = ov; v.exp_od = DW'(od); v.exp_oc = '0;
        return v;
    endfunction

    vec_t       tbl [13];
    int         acc [NCH];
    logic [DW-1:0] obs_d [$];
    logic [CW-1:0] obs_c [$];
    logic [NCH*DW-1:0] d;

    initial begin
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;

        // Channel 0 alone, samples 1..10: outputs 5 and 10, one cycle after the 5th/10th acceptance.
        tbl[0]  = mkv(4'b0001, 1'b0,  0, 4'b0000, 1'b0,  0);
        tbl[1]  = mkv(4'b0001, 1'b1,  1, 4'b0001, 1'b0,  0);
        tbl[2]  = mkv(4'b0001, 1'b1,  2, 4'b0001, 1'b0,  0);
        tbl[3]  = mkv(4'b0001, 1'b1,  3, 4'b0001, 1'b0,  0);
        tbl[4]  = mkv(4'b0001, 1'b1,  4, 4'b0001, 1'b0,  0);
        tbl[5]  = mkv(4'b0001, 1'b1,  5, 4'b0001, 1'b0,  0);
        tbl[6]  = mkv(4'b0001, 1'b1,  6, 4'b0001, 1'b1,  5);
        tbl[7]  = mkv(4'b0001, 1'b1,  7, 4'b0001, 1'b0,  5);
        tbl[8]  = mkv(4'b0001, 1'b1,  8, 4'b0001, 1'b0,  5);
        tbl[9]  = mkv(4'b0001, 1'b1,  9, 4'b0001, 1'b0,  5);
        tbl[10] = mkv(4'b0001, 1'b1, 10, 4'b0001, 1'b0,  5);
        tbl[11] = mkv(4'b0000, 1'b1,  0, 4'b0000, 1'b1, 10);
        tbl[12] = mkv(4'b0000, 1'b1,  0, 4'b0000, 1'b0, 10);

        apply(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, '0);
        adv();
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].vin, 4'b1111, 1'b0, 1'b1, tbl[i].rstn, mk4(int'(tbl[i].d0), 0, 0, 0));
            check("tbl in_ready",  32'(in_ready),  32'(tbl[i].exp_ready));
            check("tbl out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
            check("tbl out_data",  32'(out_data),  32'(tbl[i].exp_od));
            check("tbl out_chan",  32'(out_chan),  32'(tbl[i].exp_oc));
            adv();
        end

        // All channels streaming: strict rotation, one-hot ready, first outputs 5,105,205,305.
        step(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, '0);
        for (int c = 0; c < NCH; c++) acc[c] = 0;
        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'(100 * c + acc[c] + 1);
            apply(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, d);
            model_check();
            check("rot in_ready", 32'(in_ready), 32'(1 << (i % 4)));
            check("rot onehot", 32'($onehot(in_ready)), 32'd1);
            if (out_valid) begin
                obs_d.push_back(out_data);
                obs_c.push_back(out_chan);
            end
            adv();
            if (m_gnt >= 0) acc[m_gnt]++;
        end
        check("rot output count", 32'(obs_d.size()), 32'd4);
        for (int c = 0; c < NCH && c < obs_d.size(); c++) begin
            check("rot out_data", 32'(obs_d[c]), 32'(100 * c + 5));
            check("rot out_chan", 32'(obs_c[c]), 32'(c));
        end

        // Stalled stage: channel 1 at its emitting phase waits, channel 2 still accepted.
        d = mk4(33, 44, 55, 66);
        step(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, d);
        repeat (4) step(4'b0010, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        repeat (2) step(4'b0100, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        repeat (5) step(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        apply(4'b0110, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        model_check();
        check("stall in_ready", 32'(in_ready), 32'b0100);
        check("stall hold data", 32'(out_data), 32'd33);
        adv();
        apply(4'b0110, 4'b1111, 1'b0, 1'b1, 1'b1, d);
        model_check();
        check("release in_ready", 32'(in_ready), 32'b0010);
        adv();
        apply(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, d);
        model_check();
        check("release out_valid", 32'(out_valid), 32'd1);
        check("release out_data", 32'(out_data), 32'd44);
        check("release out_chan", 32'(out_chan), 32'd1);
        adv();

        // Channel 1 disabled after 3 samples: a full period restarts on re-enable.
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 1; k <= 3; k++) step(4'b0010, 4'b1111, 1'b0, 1'b1, 1'b1, mk4(0, k, 0, 0));
        for (int k = 0; k < 2; k++) begin
            apply(4'b0010, 4'b1101, 1'b0, 1'b1, 1'b1, mk4(0, 9, 0, 0));
            model_check();
            check("disabled in_ready", 32'(in_ready), 32'd0);
            adv();
        end
        for (int k = 11; k <= 15; k++) step(4'b0010, 4'b1111, 1'b0, 1'b1, 1'b1, mk4(0, k, 0, 0));
        apply(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, '0);
        model_check();
        check("reenable out_valid", 32'(out_valid), 32'd1);
        check("reenable out_data", 32'(out_data), 32'd15);
        check("reenable out_chan", 32'(out_chan), 32'd1);
        adv();

        // cnt_clr during a held output.
        d = mk4(77, 0, 0, 88);
        step(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, d);
        repeat (2) step(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        repeat (5) step(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        apply(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, d);
        model_check();
        check("clr in_ready", 32'(in_ready), 32'd0);
        adv();
        apply(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        model_check();
        check("clr hold valid", 32'(out_valid), 32'd1);
        check("clr hold data", 32'(out_data), 32'd77);
        check("clr ptr restart", 32'(in_ready), 32'b0001);
        adv();
        repeat (8) step(4'b1000, 4'b1111, 1'b0, 1'b1, 1'b1, d);

        // Reset mid-stream drops the pending output and restarts the phase.
        d = mk4(99, 0, 0, 0);
        step(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, d);
        repeat (5) step(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        apply(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, d);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst pre valid", 32'(out_valid), 32'd1);
        adv();
        apply(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, d);
        model_check();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        adv();
        repeat (5) step(4'b0001, 4'b1111, 1'b0, 1'b1, 1'b1, mk4(12, 0, 0, 0));
        apply(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, '0);
        model_check();
        check("rst phase out_valid", 32'(out_valid), 32'd1);
        check("rst phase out_data", 32'(out_data), 32'd12);
        adv();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [NCH-1:0] vin, en;
            logic clr, ordy, rstn;
            vin  = NCH'($urandom);
            en   = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : 4'b1111;
            clr  = ($urandom_range(0, 29) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            rstn = ($urandom_range(0, 99) != 0);
            d    = (NCH*DW)'({$urandom, $urandom});
            step(vin, en, clr, ordy, rstn, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
